hack_screen_reader: RTL and testbench

Scan-out engine for the Hack screen map: reads the 8K×16 screen RAM that the CPU writes and serializes it into a 512×256 monochrome pixel stream with sync and data-enable for the MiSTer video path. It sits between the dual-port screen RAM's read port and the video output stage. It generates its own raster timing and fetches one word per 16 pixels, so screen RAM needs no arbitration with the CPU write port.

---
 rtl/hack_video_pkg.sv | 8 +
 rtl/hack_video_timing.sv | 49 ++++
 rtl/hack_screen_reader.sv | 85 ++++++++
 tb/tb_hack_screen_reader.sv | 96 +++++++++
 4 files changed

// File: rtl/hack_video_pkg.sv
// hack_video_pkg: shared geometry constants for the Hack screen scan-out path.
package hack_video_pkg;
  localparam int SCREEN_W      = 512;
  localparam int SCREEN_H      = 256;
  localparam int WORDS_PER_ROW = 32;
  localparam int SCREEN_ADDR_W = 13;
  localparam int WORD_W        = 16;
endpackage

// File: rtl/hack_video_timing.sv
// hack_video_timing: raster counters, active-region flag and sync decode, advancing on ce_pix.
module hack_video_timing
  import hack_video_pkg::*;
#(
  parameter int H_TOTAL  = 640,
  parameter int HS_START = 544,
  parameter int HS_WIDTH = 48,
  parameter int V_TOTAL  = 320,
  parameter int VS_START = 280,
  parameter int VS_WIDTH = 4,
  parameter int HW       = $clog2(H_TOTAL),
  parameter int VW       = $clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          ce_pix,
  output logic [HW-1:0] hcount,
  output logic [VW-1:0] vcount,
  output logic [VW-1:0] nextrow,
  output logic          active,
  output logic          hsync,
  output logic          vsync
);
  logic [HW-1:0] hcount_q, hcount_d;
  logic [VW-1:0] vcount_q, vcount_d;
  logic          h_wrap, v_wrap;
  always_comb begin
    h_wrap   = hcount_q == HW'(H_TOTAL - 1);
    v_wrap   = vcount_q == VW'(V_TOTAL - 1);
    hcount_d = ce_pix ? (h_wrap ? '0 : hcount_q + 1'b1) : hcount_q;
    vcount_d = (ce_pix && h_wrap) ? (v_wrap ? '0 : vcount_q + 1'b1) : vcount_q;
    nextrow  = v_wrap ? '0 : vcount_q + 1'b1;
    active   = hcount_q < HW'(SCREEN_W) && vcount_q < VW'(SCREEN_H);
    hsync    = hcount_q >= HW'(HS_START) && hcount_q < HW'(HS_START + HS_WIDTH);
    vsync    = vcount_q >= VW'(VS_START) && vcount_q < VW'(VS_START + VS_WIDTH);
    hcount   = hcount_q;
    vcount   = vcount_q;
  end
  // Reset parks the raster just before row 0 so the first frame is whole.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcount_q <= HW'(H_TOTAL - 2);
      vcount_q <= VW'(V_TOTAL - 1);
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end
endmodule

// File: rtl/hack_screen_reader.sv
// hack_screen_reader: fetches Hack screen RAM words and serializes them to pixels with sync/DE.
// HACK_SCREEN_FRAME_PULSE_EN adds a frame_end pulse on the last active pixel.
module hack_screen_reader
  import hack_video_pkg::*;
#(
  parameter int H_TOTAL  = 640,
  parameter int HS_START = 544,
  parameter int HS_WIDTH = 48,
  parameter int V_TOTAL  = 320,
  parameter int VS_START = 280,
  parameter int VS_WIDTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ce_pix,
  output logic                     scr_rd,
  output logic [SCREEN_ADDR_W-1:0] scr_addr,
  input  logic [WORD_W-1:0]        scr_data,
  output logic                     pix,
  output logic                     de,
  output logic                     hs_n,
  output logic                     vs_n
`ifdef HACK_SCREEN_FRAME_PULSE_EN
  ,
  output logic                     frame_end
`endif
);
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  logic [HW-1:0]     hcount;
  logic [VW-1:0]     vcount, nextrow;
  logic              active, hsync, vsync, next_in, fetch, load;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic              pix_q, pix_d, de_q, de_d, hs_n_q, hs_n_d, vs_n_q, vs_n_d;
  hack_video_timing #(
    .H_TOTAL(H_TOTAL), .HS_START(HS_START), .HS_WIDTH(HS_WIDTH),
    .V_TOTAL(V_TOTAL), .VS_START(VS_START), .VS_WIDTH(VS_WIDTH),
    .HW(HW), .VW(VW)
  ) u_timing (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix),
    .hcount(hcount), .vcount(vcount), .nextrow(nextrow),
    .active(active), .hsync(hsync), .vsync(vsync)
  );
  // The strobe is combinational so RAM data lands one clk before the load edge even with ce_pix tied high.
  always_comb begin
    next_in  = nextrow < VW'(SCREEN_H);
    fetch    = (hcount == HW'(H_TOTAL - 2) && next_in) ||
               (active && hcount[3:0] == 4'd14 && hcount < HW'(SCREEN_W - 2));
    load     = (hcount == HW'(H_TOTAL - 1) && next_in) ||
               (active && hcount[3:0] == 4'd15 && hcount < HW'(SCREEN_W - 1));
    scr_rd   = reset_n && ce_pix && fetch;
    scr_addr = hcount < HW'(SCREEN_W) ? SCREEN_ADDR_W'({vcount, hcount[8:4]} + 1'b1)
                                      : SCREEN_ADDR_W'({nextrow, 5'd0});
    shift_d  = ce_pix ? (load ? scr_data : (active ? shift_q >> 1 : shift_q)) : shift_q;
    pix_d    = ce_pix ? active && shift_q[0] : pix_q;
    de_d     = ce_pix ? active : de_q;
    hs_n_d   = ce_pix ? !hsync : hs_n_q;
    vs_n_d   = ce_pix ? !vsync : vs_n_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      shift_q <= '0;
      pix_q   <= 1'b0;
      de_q    <= 1'b0;
      hs_n_q  <= 1'b1;
      vs_n_q  <= 1'b1;
    end else begin
      shift_q <= shift_d;
      pix_q   <= pix_d;
      de_q    <= de_d;
      hs_n_q  <= hs_n_d;
      vs_n_q  <= vs_n_d;
    end
  end
  assign pix  = pix_q;
  assign de   = de_q;
  assign hs_n = hs_n_q;
  assign vs_n = vs_n_q;
`ifdef HACK_SCREEN_FRAME_PULSE_EN
  logic frame_end_q, frame_end_d;
  always_comb frame_end_d = ce_pix && hcount == HW'(SCREEN_W - 1) && vcount == VW'(SCREEN_H - 1);
  always_ff @(posedge clk) frame_end_q <= reset_n && frame_end_d;
  assign frame_end = frame_end_q;
`endif
endmodule

// File: tb/tb_hack_screen_reader.sv
// tb_hack_screen_reader: random ce_pix / reset stimulus against a raster-position reference model.
module tb_hack_screen_reader;
  localparam int H  = 640;
  localparam int V  = 320;
  localparam int P0 = (V - 1) * H + H - 2;
  logic        clk = 1'b0, reset_n = 1'b0, ce_pix = 1'b0;
  logic        scr_rd, pix, de, hs_n, vs_n;
  logic [12:0] scr_addr;
  logic [15:0] scr_data = '0;
  logic [15:0] ram [8192];
  int          n_vec = 0, n_bad = 0, pos = 0, exp_addr = 0;
  bit          valid = 0, after_rst = 0;
  logic        e_pix, e_de, e_hs_n, e_vs_n;

  hack_screen_reader dut (
    .clk(clk), .reset_n(reset_n), .ce_pix(ce_pix),
    .scr_rd(scr_rd), .scr_addr(scr_addr), .scr_data(scr_data),
    .pix(pix), .de(de), .hs_n(hs_n), .vs_n(vs_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (scr_rd) scr_data <= ram[scr_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at pos=%0d (x=%0d y=%0d): got %0h expected %0h", tag, pos, pos % H, pos / H, got, exp);
    end
  endtask

  function automatic bit fetch_at(input int p);
    int x = p % H;
    int y = p / H;
    return (x == H - 2 && (y + 1) % V < 256) || (y < 256 && x < 510 && x % 16 == 14);
  endfunction

  // Model: each ce_pix edge after reset processes the next raster position in order.
  task automatic step(input bit ce, input bit rn);
    logic [15:0] w;
    int x, y;
    bit rd;
    ce_pix  = ce;
    reset_n = rn;
    @(negedge clk);
    if (valid) begin
      rd = rn && ce && fetch_at(pos);
      chk("scr_rd", 32'(scr_rd), 32'(rd));
      if (after_rst) chk("addr_rst", 32'(scr_addr), 0);
      if (rd) begin
        chk("scr_addr", 32'(scr_addr), exp_addr);
        exp_addr = (exp_addr + 1) % 8192;
      end
    end
    @(posedge clk);
    #1;
    if (!rn) begin
      valid = 1; after_rst = 1; pos = P0; exp_addr = 0;
      e_pix = 0; e_de = 0; e_hs_n = 1; e_vs_n = 1;
    end else if (ce) begin
      x = pos % H;
      y = pos / H;
      e_de   = x < 512 && y < 256;
      w      = e_de ? ram[y * 32 + x / 16] : 16'h0;
      e_pix  = e_de && w[x % 16];
      e_hs_n = !(x >= 544 && x < 592);
      e_vs_n = !(y >= 280 && y < 284);
      pos = (pos + 1) % (H * V);
      after_rst = 0;
    end
    if (valid) begin
      chk("pix", 32'(pix), 32'(e_pix));
      chk("de", 32'(de), 32'(e_de));
      chk("hs_n", 32'(hs_n), 32'(e_hs_n));
      chk("vs_n", 32'(vs_n), 32'(e_vs_n));
    end
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) ram[i] = 16'($urandom);
    for (int i = 0; i < 64; i++) ram[i] = 16'h0;
    ram[0]  = 16'h0001;
    ram[33] = 16'h8000;
    repeat (3) step(1'b1, 1'b0);
    repeat (3 * H + 2) step(1'b1, 1'b1);
    repeat ($urandom_range(50, 300)) step(1'b1, 1'b1);
    step(1'($urandom_range(0, 1)), 1'b0);
    for (int i = 0; i < 4 * 2 * H + 16; i++) step(i % 4 == 3, 1'b1);
    repeat (3000) step($urandom_range(0, 1) == 1, 1'b1);
    step(1'b0, 1'b0);
    repeat (4000) step($urandom_range(0, 2) == 0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
